// File: rtl/load_hazard_unit.sv
// Load-use stall, EX bubble and data-memory freeze control.
// Optional perf counters are built only when HAZARD_PERF_EN is defined.
module load_hazard_unit
`ifdef HAZARD_PERF_EN
#(
  parameter int PERF_W = 32
)
`endif
(
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_reg_write,
  input  logic       id_mem_read,
  input  logic       id_mem_write,
  input  logic       ex_flush,
  input  logic       mem_ready,
  output logic       stall_id,
  output logic       bubble_ex,
  output logic       freeze,
`ifdef HAZARD_PERF_EN
  output logic [PERF_W-1:0] perf_load_use,
  output logic [PERF_W-1:0] perf_mem_wait,
`endif
  output logic       mem_req
);

  typedef struct packed {
    logic       valid;
    logic       is_load;
    logic       is_mem;
    logic [4:0] rd;
  } slot_t;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

  slot_t  ex_slot;
  slot_t  mem_slot;
  slot_t  id_slot;
  state_t state_q;
  state_t state_d;
  logic   hit_rs1;
  logic   hit_rs2;
  logic   advance;

  // x0 loads never produce a hazard, so they are recorded as non-loads
  always_comb begin
    id_slot         = '0;
    id_slot.valid   = 1'b1;
    id_slot.is_load = id_mem_read & id_reg_write & (|id_rd);
    id_slot.is_mem  = id_mem_read | id_mem_write;
    id_slot.rd      = id_rd;
  end

  assign hit_rs1 = id_use_rs1 & (id_rs1 == ex_slot.rd);
  assign hit_rs2 = id_use_rs2 & (id_rs2 == ex_slot.rd);

  assign stall_id = id_valid & ~ex_flush
                  & ex_slot.valid & ex_slot.is_load
                  & (hit_rs1 | hit_rs2);

  assign bubble_ex = (stall_id | ex_flush) & ~freeze;
  assign advance   = id_valid & ~stall_id & ~ex_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_slot  <= '0;
      mem_slot <= '0;
    end else if (!freeze) begin
      mem_slot <= ex_slot;
      ex_slot  <= advance ? id_slot : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:  if (mem_req & ~mem_ready) state_d = WAIT;
      WAIT: if (mem_ready)            state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    mem_req = mem_slot.valid & mem_slot.is_mem;
    freeze  = mem_req & ~mem_ready;
  end

  // a pending access may only be abandoned by reset
  a_wait_holds_req: assert property (
    @(posedge clk) disable iff (rst)
    (state_q == WAIT) |-> mem_req
  );

`ifdef HAZARD_PERF_EN
  localparam logic [PERF_W-1:0] ONE = {{(PERF_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_load_use <= '0;
      perf_mem_wait <= '0;
    end else begin
      if (stall_id & ~freeze & ~(&perf_load_use))
        perf_load_use <= perf_load_use + ONE;
      if (freeze & ~(&perf_mem_wait))
        perf_mem_wait <= perf_mem_wait + ONE;
    end
  end
`endif

endmodule

// File: tb/tb_load_hazard_unit.sv
// Scoreboard bench for load_hazard_unit: directed test-plan
// scenarios followed by randomized traffic against a reference model.
module tb_load_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       id_mem_write;
  logic       ex_flush;
  logic       mem_ready;
  logic       stall_id;
  logic       bubble_ex;
  logic       freeze;
  logic       mem_req;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_load_use;
  logic [31:0] perf_mem_wait;
`endif

  always #5 clk = ~clk;

  load_hazard_unit dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_mem_write (id_mem_write),
    .ex_flush     (ex_flush),
    .mem_ready    (mem_ready),
    .stall_id     (stall_id),
    .bubble_ex    (bubble_ex),
    .freeze       (freeze),
`ifdef HAZARD_PERF_EN
    .perf_load_use(perf_load_use),
    .perf_mem_wait(perf_mem_wait),
`endif
    .mem_req      (mem_req)
  );

  // instruction as the ISA sees it, not as the RTL encodes it
  typedef struct {
    bit v;
    bit mr;
    bit mw;
    bit rw;
    int rd;
  } ins_t;

  typedef struct {
    bit      stall;
    bit      bubble;
    bit      frz;
    bit      req;
    longint  plu;
    longint  pmw;
  } exp_t;

  exp_t   q[$];
  ins_t   ex_m;
  ins_t   mem_m;
  longint plu_m;
  longint pmw_m;
  int     checks;
  int     passes;
  exp_t   last;

  localparam longint SAT = 64'h0000_0000_FFFF_FFFF;

  function automatic ins_t empty_ins();
    ins_t n;
    n.v = 0; n.mr = 0; n.mw = 0; n.rw = 0; n.rd = 0;
    return n;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    bit   pending_load;
    bit   uses;
    pending_load = ex_m.v && ex_m.mr && ex_m.rw && ex_m.rd != 0;
    uses = (id_use_rs1 && int'(id_rs1) == ex_m.rd)
        || (id_use_rs2 && int'(id_rs2) == ex_m.rd);
    e.stall  = id_valid && !ex_flush && pending_load && uses;
    e.req    = mem_m.v && (mem_m.mr || mem_m.mw);
    e.frz    = e.req && !mem_ready;
    e.bubble = (e.stall || ex_flush) && !e.frz;
    e.plu    = plu_m;
    e.pmw    = pmw_m;
    return e;
  endfunction

  task automatic tick(input bit chk);
    exp_t e;
    ins_t n;
    e = predict();
    if (chk) q.push_back(e);
    last = e;
    @(posedge clk);
    if (rst) begin
      ex_m  = empty_ins();
      mem_m = empty_ins();
      plu_m = 0;
      pmw_m = 0;
    end else begin
      if (e.stall && !e.frz && plu_m < SAT) plu_m++;
      if (e.frz && pmw_m < SAT) pmw_m++;
      if (!e.frz) begin
        mem_m = ex_m;
        n = empty_ins();
        if (id_valid && !e.stall && !ex_flush) begin
          n.v  = 1;
          n.mr = id_mem_read;
          n.mw = id_mem_write;
          n.rw = id_reg_write;
          n.rd = int'(id_rd);
        end
        ex_m = n;
      end
    end
    #1;
  endtask

  task automatic set_id(input bit v, input int rs1, input int rs2,
                        input bit u1, input bit u2, input int rd,
                        input bit rw, input bit mr, input bit mw);
    id_valid     = v;
    id_rs1       = 5'(rs1);
    id_rs2       = 5'(rs2);
    id_use_rs1   = u1;
    id_use_rs2   = u2;
    id_rd        = 5'(rd);
    id_reg_write = rw;
    id_mem_read  = mr;
    id_mem_write = mw;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic lw(input int rd);
    set_id(1, 1, 0, 1, 0, rd, 1, 1, 0);
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, want);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("stall_id",  64'(stall_id),  64'(e.stall));
      chk("bubble_ex", 64'(bubble_ex), 64'(e.bubble));
      chk("freeze",    64'(freeze),    64'(e.frz));
      chk("mem_req",   64'(mem_req),   64'(e.req));
`ifdef HAZARD_PERF_EN
      chk("perf_load_use", 64'(perf_load_use), e.plu);
      chk("perf_mem_wait", 64'(perf_mem_wait), e.pmw);
`endif
    end
  end

  initial begin
    checks = 0;
    passes = 0;
    ex_m   = empty_ins();
    mem_m  = empty_ins();
    plu_m  = 0;
    pmw_m  = 0;
    nop();
    ex_flush  = 0;
    mem_ready = 1;
    rst       = 1;
    tick(0);
    tick(1);
    rst = 0;

    // lw x5 then dependent add
    lw(5);                            tick(1);
    set_id(1, 5, 1, 1, 1, 6, 1, 0, 0); tick(1); tick(1);
    nop();                            tick(1); tick(1); tick(1);

    // x0 load and unused rs2 must not stall
    lw(0);                            tick(1);
    set_id(1, 0, 0, 1, 1, 7, 1, 0, 0); tick(1);
    lw(5);                            tick(1);
    set_id(1, 1, 5, 1, 0, 7, 1, 0, 0); tick(1);
    nop();                            tick(1); tick(1); tick(1);

    // memory three cycles late
    lw(5);          tick(1);
    nop();          tick(1);
    mem_ready = 0;  tick(1); tick(1); tick(1);
    mem_ready = 1;  tick(1); tick(1);

    // flush kills a load-use pair
    lw(5);                            tick(1);
    set_id(1, 5, 0, 1, 0, 6, 1, 0, 0);
    ex_flush = 1;                     tick(1);
    ex_flush = 0; nop();              tick(1); tick(1); tick(1);

    // flush held through a freeze
    lw(5);          tick(1);
    nop();          tick(1);
    mem_ready = 0;
    set_id(1, 2, 3, 1, 1, 4, 1, 0, 0);
    ex_flush  = 1;  tick(1); tick(1);
    mem_ready = 1;  tick(1);
    ex_flush  = 0; nop(); tick(1); tick(1);

    // reset in the middle of a wait
    lw(5);          tick(1);
    nop();          tick(1);
    mem_ready = 0;  tick(1);
    rst = 1;        tick(1);
    rst = 0;        tick(1);
    mem_ready = 1;  tick(1);

    for (int i = 0; i < 1500; i++) begin
      if (!(last.frz || last.stall)) begin
        int k;
        k = $urandom_range(0, 9);
        set_id($urandom_range(0, 7) != 0,
               $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 3), $urandom_range(0, 3) != 0,
               k < 4, k == 4 || k == 5);
      end
      if (!last.frz) ex_flush = $urandom_range(0, 9) == 0;
      mem_ready = $urandom_range(0, 9) < 6;
      rst       = $urandom_range(0, 199) == 0;
      tick(1);
    end
    rst = 0;
    nop();
    ex_flush = 0;
    tick(0);

    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: got %0d, expected 0", q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
